// File: rtl/crc_retry_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// crc_retry_controller : buffers words, drives the CRC chain, retries on error
// Revision: 1.0
// ============================================================================
module crc_retry_controller #(
    parameter int N         = 11,
    parameter int M         = 5,
    parameter int LAT       = 2,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         inject_en,
    output logic [N-1:0] crc_data_in,
    output logic         crc_error_enable,
    input  logic [N-1:0] crc_data_out,
    input  logic         crc_error_check,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    output logic         m_drop,
    output logic [7:0]   retry_count,
    output logic [7:0]   drop_count,
    output logic         busy
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int c_rw = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_lat   = c_cw'(LAT);
    localparam logic [c_rw-1:0] c_max   = c_rw'(MAX_RETRY);

    // The polynomial bypasses this block; M is only sanity-checked here.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (M < 1)) begin : g_param_check
            $error("crc_retry_controller: DEPTH must be a power of two >= 2 and M >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [c_cw-1:0] r_cnt;
    logic [c_rw-1:0] r_attempt;
    logic            w_push;
    logic            w_pop;

    assign s_ready = (r_count != c_depth);
    assign w_push  = s_valid && s_ready;
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
    assign busy    = (r_state == S_DRIVE) || (r_count != '0);

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // crc_data_in doubles as the hold register for the word being attempted.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_rd_ptr         <= '0;
            r_cnt            <= '0;
            r_attempt        <= '0;
            crc_data_in      <= '0;
            crc_error_enable <= 1'b0;
            m_data           <= '0;
            m_valid          <= 1'b0;
            m_drop           <= 1'b0;
            retry_count      <= '0;
            drop_count       <= '0;
        end else begin
            m_valid <= 1'b0;
            m_drop  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        crc_data_in      <= r_mem[r_rd_ptr];
                        crc_error_enable <= inject_en;
                        r_rd_ptr         <= r_rd_ptr + 1'b1;
                        r_attempt        <= '0;
                        r_cnt            <= '0;
                        r_state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != c_lat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!crc_error_check) begin
                        m_data  <= crc_data_out;
                        m_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_attempt != c_max) begin
                        r_attempt        <= r_attempt + 1'b1;
                        r_cnt            <= '0;
                        crc_error_enable <= 1'b0;
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                    end else begin
                        m_drop           <= 1'b1;
                        crc_error_enable <= 1'b0;
                        r_state          <= S_IDLE;
                        if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_retry_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_crc_retry_controller : scoreboard bench with a LAT-cycle CRC chain model
// Revision: 1.0
// ============================================================================
module tb_crc_retry_controller;

    localparam int N         = 11;
    localparam int M         = 5;
    localparam int LAT       = 2;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;

    logic         Clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         inject_en = 1'b0;
    logic [N-1:0] crc_data_in;
    logic         crc_error_enable;
    logic [N-1:0] crc_data_out;
    logic         crc_error_check;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_drop;
    logic [7:0]   retry_count;
    logic [7:0]   drop_count;
    logic         busy;

    crc_retry_controller #(
        .N(N), .M(M), .LAT(LAT), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .Clk(Clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .inject_en(inject_en),
        .crc_data_in(crc_data_in), .crc_error_enable(crc_error_enable),
        .crc_data_out(crc_data_out), .crc_error_check(crc_error_check),
        .m_data(m_data), .m_valid(m_valid), .m_drop(m_drop),
        .retry_count(retry_count), .drop_count(drop_count), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Chain model: two-stage delay on data and error flag, optional forced error.
    logic [N-1:0] r_d1, r_d2;
    logic         r_e1, r_e2;
    bit           force_err = 1'b0;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_d1 <= '0; r_d2 <= '0; r_e1 <= 1'b0; r_e2 <= 1'b0;
        end else begin
            r_d1 <= crc_data_in;      r_d2 <= r_d1;
            r_e1 <= crc_error_enable; r_e2 <= r_e1;
        end
    end
    assign crc_data_out    = r_d2;
    assign crc_error_check = force_err | r_e2;

    typedef struct {
        bit           is_drop;
        logic [N-1:0] data;
        int           at_edge;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           edge_cnt = 0;
    int           free_edge = 0;
    logic [N-1:0] last_data = '0;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    always @(negedge Clk) begin : mon
        exp_t e;
        if (!reset && (m_valid || m_drop)) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {30'd0, m_valid, m_drop}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_drop",  {31'd0, m_drop}, {31'd0, e.is_drop});
                chk("out_valid", {31'd0, m_valid}, {31'd0, !e.is_drop});
                chk("out_data",  {21'd0, m_data}, {21'd0, e.data});
                chk("out_edge",  edge_cnt, e.at_edge);
            end
        end
    end

    // Handshake one word; schedule its expected outcome from the timing model.
    task automatic push_word(input logic [N-1:0] d, input int retries,
                             input bit drop, input bit expect_out);
        int  pe, pop_e, samp, guard;
        bit  rdy;
        exp_t e;
        s_valid = 1'b1;
        s_data  = d;
        guard   = 0;
        forever begin
            rdy = s_ready;
            @(posedge Clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 400) begin
                chk("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_valid = 1'b0;
        pe = edge_cnt;
        if (expect_out) begin
            pop_e = (pe + 1 > free_edge) ? pe + 1 : free_edge;
            samp  = pop_e + (LAT + 1) * (retries + 1);
            free_edge = samp + 1;
            e.is_drop = drop;
            e.data    = drop ? last_data : d;
            e.at_edge = samp;
            if (!drop) last_data = d;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        s_valid   = 1'b0;
        inject_en = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        sb.delete();
        free_edge = 0;
        last_data = '0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_crc_data_in", {21'd0, crc_data_in}, 32'd0);
        chk("rst_err_en",      {31'd0, crc_error_enable}, 32'd0);
        chk("rst_m_data",      {21'd0, m_data}, 32'd0);
        chk("rst_m_valid",     {31'd0, m_valid}, 32'd0);
        chk("rst_m_drop",      {31'd0, m_drop}, 32'd0);
        chk("rst_retry",       {24'd0, retry_count}, 32'd0);
        chk("rst_drop",        {24'd0, drop_count}, 32'd0);
        chk("rst_busy",        {31'd0, busy}, 32'd0);
        chk("rst_s_ready",     {31'd0, s_ready}, 32'd1);

        // Clean word
        push_word(11'h5A3, 0, 1'b0, 1'b1);
        chk("clean_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("clean_drive_data", {21'd0, crc_data_in}, 32'h5A3);
            chk("clean_drive_en",   {31'd0, crc_error_enable}, 32'd0);
        end
        drain(50);
        chk("clean_m_data", {21'd0, m_data}, 32'h5A3);
        chk("clean_retry",  {24'd0, retry_count}, 32'd0);
        chk("clean_busy_end", {31'd0, busy}, 32'd0);

        // Injected error, one retry
        do_reset();
        inject_en = 1'b1;
        push_word(11'h7FF, 1, 1'b0, 1'b1);
        @(posedge Clk); #1;
        inject_en = 1'b0;
        chk("inj_first_en",   {31'd0, crc_error_enable}, 32'd1);
        chk("inj_first_data", {21'd0, crc_data_in}, 32'h7FF);
        repeat (3) @(posedge Clk);
        #1;
        chk("inj_retry_en",    {31'd0, crc_error_enable}, 32'd0);
        chk("inj_retry_count", {24'd0, retry_count}, 32'd1);
        drain(50);
        chk("inj_m_data", {21'd0, m_data}, 32'h7FF);
        chk("inj_retry",  {24'd0, retry_count}, 32'd1);
        chk("inj_drop",   {24'd0, drop_count}, 32'd0);

        // Forced error: drop after all attempts, then counter saturation
        do_reset();
        force_err = 1'b1;
        push_word(11'h001, MAX_RETRY, 1'b1, 1'b1);
        drain(100);
        chk("drop_count1", {24'd0, drop_count}, 32'd1);
        chk("drop_retry3", {24'd0, retry_count}, 32'd3);
        chk("drop_m_data", {21'd0, m_data}, 32'd0);
        for (int i = 0; i < 85; i++) begin
            push_word(N'(i + 2), MAX_RETRY, 1'b1, 1'b1);
        end
        drain(3000);
        chk("sat_retry", {24'd0, retry_count}, 32'd255);
        chk("sat_drop",  {24'd0, drop_count}, 32'd86);
        force_err = 1'b0;

        // Burst through the FIFO with s_valid held
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_word(N'(11'h010 + i), 0, 1'b0, 1'b1);
            if (i == 4) begin
                chk("burst_full_ready", {31'd0, s_ready}, 32'd0);
                chk("burst_full_busy",  {31'd0, busy}, 32'd1);
            end
        end
        drain(100);
        chk("burst_m_data", {21'd0, m_data}, 32'h015);
        chk("burst_ready",  {31'd0, s_ready}, 32'd1);

        // Reset in the second DRIVE cycle with two words queued
        do_reset();
        inject_en = 1'b1;
        push_word(11'h111, 0, 1'b0, 1'b0);
        push_word(11'h122, 0, 1'b0, 1'b0);
        inject_en = 1'b0;
        push_word(11'h133, 0, 1'b0, 1'b0);
        chk("mid_err_en",  {31'd0, crc_error_enable}, 32'd1);
        chk("mid_ready",   {31'd0, s_ready}, 32'd0 + ((DEPTH > 2) ? 32'd1 : 32'd0));
        reset = 1'b1;
        #1;
        chk("arst_err_en",  {31'd0, crc_error_enable}, 32'd0);
        chk("arst_ready",   {31'd0, s_ready}, 32'd1);
        chk("arst_busy",    {31'd0, busy}, 32'd0);
        chk("arst_data_in", {21'd0, crc_data_in}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        sb.delete();
        free_edge = 0;
        last_data = '0;
        repeat (12) @(posedge Clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        push_word(11'h2AA, 0, 1'b0, 1'b1);
        drain(50);
        chk("post_rst_m_data", {21'd0, m_data}, 32'h2AA);
        chk("post_rst_retry",  {24'd0, retry_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/crc_retry_controller.md
# crc_retry_controller

Upstream link controller for the CRC encode/inject/check chain. It buffers incoming data words, drives each one into the chain's data and error-enable inputs, and waits the chain's fixed latency. It then samples the error flag and either delivers the checked word or retransmits it, up to a bounded retry count. Error injection applies only to the first attempt of a word, so a retry exercises recovery.

## Interface
- N, 11, data word width (matches chain data width)
- M, 5, polynomial width (pass-through only)
- LAT, 2, cycles from chain data_in/error_enable change to valid data_out/error_check
- DEPTH, 4, input FIFO depth (power of two)
- MAX_RETRY, 3, retransmissions allowed after the first attempt
- Clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- s_data  in  N  input word
- s_valid  in  1  input word valid
- s_ready  out  1  FIFO not full
- inject_en  in  1  request error injection on the first attempt of the next popped word
- crc_data_in  out  N  to chain data_in
- crc_error_enable  out  1  to chain error_enable
- crc_data_out  in  N  from chain data_out
- crc_error_check  in  1  from chain error_check (1 = error)
- m_data  out  N  delivered word
- m_valid  out  1  one-cycle pulse, no backpressure
- m_drop  out  1  one-cycle pulse, word abandoned
- retry_count  out  8  saturating count of retransmissions
- drop_count  out  8  saturating count of drops
- busy  out  1  FSM not in IDLE or FIFO non-empty

## Operation
- FIFO: push when s_valid && s_ready. s_ready = !full, taken from registered occupancy only, so a same-cycle pop never raises s_ready. Push and pop in the same cycle are both honoured. Order is preserved.
- FSM states: IDLE, DRIVE.
- IDLE, FIFO non-empty:
  - Pop head into hold register.
  - Latch inject_en into inj.
  - Set attempt=0 and cnt=0.
  - Go to DRIVE.
- DRIVE:
  - crc_data_in = hold, stable for the whole state.
  - crc_error_enable = inj && attempt==0.
  - cnt increments each cycle.
  - On the cycle with cnt==LAT, sample crc_error_check and crc_data_out.
- Sample result, clean: register m_data = sampled crc_data_out, pulse m_valid, go to IDLE.
- Sample result, error with attempt<MAX_RETRY: attempt+1, retry_count+1, cnt=0, stay in DRIVE (error_enable now 0).
- Sample result, error with attempt==MAX_RETRY: pulse m_drop, drop_count+1, go to IDLE. m_data is unchanged.
- Counters saturate at 255. attempt is sized for MAX_RETRY.
- polynomial is not handled here; it is wired directly to the chain.

## Timing
- Reset values:
  - crc_data_in, crc_error_enable, m_data, m_valid, m_drop, retry_count, drop_count, busy: 0.
  - FIFO empty, FSM in IDLE, s_ready=1.
- All outputs except s_ready and busy are registered.
- Latency: push at edge E0, pop at E1, DRIVE for cycles E1..E3 (LAT=2), sample at E4, m_valid high in cycle after E4. That is LAT+2 edges from push to m_valid, with no errors and an empty FIFO.
- Throughput: one word per LAT+2 cycles clean. Each retry adds LAT+1 cycles.
- The IDLE cycle in which m_valid is high may also pop the next word.
- inject_en is sampled only at pop. Changes during DRIVE are ignored.
- Reset asserted mid-DRIVE:
  - In-flight word lost, FIFO cleared.
  - No m_valid or m_drop emitted.
  - Counters cleared.
  - crc_error_enable drops immediately (asynchronous).

## Test plan
Bench uses a chain model with data_out = data_in delayed LAT cycles and error_check = error_enable delayed LAT cycles, unless forced.

- Reset then release, idle -> all outputs 0, s_ready=1, busy=0.
- Push 11'h5A3, inject_en=0 -> crc_data_in=11'h5A3 for 3 cycles, m_valid 4 edges after push, m_data=11'h5A3, retry_count=0.
- Push 11'h7FF, inject_en=1 -> error_enable=1 on first attempt only, one retry, m_valid with m_data=11'h7FF 7 edges after push, retry_count=1, drop_count=0.
- Force error_check=1 permanently, push 11'h001 -> 4 attempts, m_drop pulse after 13 edges, drop_count=1, retry_count=3, no m_valid.
- Push 6 words (11'h010..11'h015) on consecutive cycles, s_valid held -> s_ready low while 4 words are buffered, all 6 delivered in order, spaced 4 cycles apart.
- Assert reset in the second DRIVE cycle with 2 words queued -> no m_valid, FIFO empty, s_ready=1. A fresh push of 11'h2AA then completes normally.
